pll_reconfig_ctrl: RTL
======================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameter NUM_CH, default 1, number of PLL output channels controlled (1..7).
REQ-002 Parameter RST_CYCLES, default 16, pll_reset pulse length in clkin cycles.
REQ-003 Parameter LOCK_FILT, default 64, cycles synchronized lock must stay high before declaring locked.
REQ-004 Parameter LOCK_TIMEOUT, default 4096, cycles allowed from pll_reset release to first lock.
REQ-005 Parameter MAX_RETRY, default 3, consecutive failed lock attempts before FAULT.
REQ-006 Parameter GATE_CYCLES, default 4, cycles enclk held low before a reconfiguration reset.
REQ-007 Parameters DEF_IDSEL, DEF_FBDSEL (6 bits, default 0), DEF_ODSEL (NUM_CH*7 bits, default 0), power-up divider selects.
REQ-008 clkin  in  1  sole clock, PLL reference clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 cfg_valid  in  1  new divider configuration offered.
REQ-011 cfg_ready  out  1  configuration accepted when high with cfg_valid.
REQ-012 cfg_idsel, cfg_fbdsel  in  6 each  requested input/feedback divider selects.
REQ-013 cfg_odsel  in  NUM_CH*7  requested output divider selects, channel i at [7i+6:7i].
REQ-014 pll_lock  in  1  raw PLL LOCK, asynchronous to clkin.
REQ-015 pll_reset, pll_pwd  out  1 each  PLL RESET and PLLPWD drives.
REQ-016 idsel, fbdsel  out  6 each; odsel  out  NUM_CH*7  registered dynamic divider selects to PLL.
REQ-017 enclk  out  NUM_CH  per-channel ENCLK gates.
REQ-018 locked, busy, err  out  1 each  status; retry_cnt  out  3  failed attempts since last lock.

Function
REQ-019 pll_lock SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (lock_s).
REQ-020 FSM states SHALL be RST, WAIT_LOCK, FILTER, RUN, GATE, FAULT.
REQ-021 RST: pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with pll_reset=0.
REQ-022 WAIT_LOCK: lock_s=1 -> FILTER; LOCK_TIMEOUT cycles elapsed without lock -> failure.
REQ-023 FILTER: counter counts consecutive lock_s=1 cycles; lock_s=0 -> counter cleared, back to WAIT_LOCK (timeout counter keeps running); count reaches LOCK_FILT -> RUN.
REQ-024 Failure: retry_cnt increments (saturating at 7); retry_cnt < MAX_RETRY after increment -> RST, else FAULT.
REQ-025 RUN: locked=1, busy=0, enclk all ones from the first RUN cycle; retry_cnt cleared on entry.
REQ-026 cfg_ready SHALL be 1 only in RUN and FAULT; a cfg_valid&cfg_ready cycle latches all cfg_* into idsel/fbdsel/odsel on the next edge and enters GATE.
REQ-027 GATE: enclk=0, locked=0, busy=1 for GATE_CYCLES cycles, then RST.
REQ-028 FAULT: err=1, pll_pwd=1, pll_reset=1, enclk=0, locked=0, busy=0; exits only by cfg handshake (err cleared, retry_cnt cleared, -> GATE) or rst_n.
REQ-029 In every state except RUN, enclk=0 and locked=0; busy=1 in RST, WAIT_LOCK, FILTER, GATE.
REQ-030 cfg_valid in RUN coincident with lock_s falling SHALL be accepted; the handshake takes priority over lock-loss handling.
REQ-031 Divider select outputs SHALL change only on handshake or reset, never while pll_reset=0 outside RUN.

Reset
REQ-032 rst_n low SHALL asynchronously force: state=RST, pll_reset=1, pll_pwd=0, enclk=0, locked=0, busy=1, err=0, cfg_ready=0, retry_cnt=0, all counters 0, synchronizer 0, idsel/fbdsel/odsel = DEF_* values.
REQ-033 After rst_n deasserts, RST SHALL count a full RST_CYCLES pulse from its first clkin edge.

Configuration
REQ-034 Macro PLL_AUTO_RELOCK_EN defined: lock_s=0 in RUN -> enclk=0, locked=0, retry_cnt increments, -> RST (relock attempt).
REQ-035 PLL_AUTO_RELOCK_EN undefined: lock_s=0 in RUN -> FAULT directly; retry logic still applies to initial lock and reconfiguration.

Verification (defaults unless stated)
REQ-036 Release reset, pll_lock rises 100 cycles after pll_reset falls -> pll_reset high exactly 16 cycles, locked=1 and enclk=1 at 100+2+64 cycles after pll_reset fall (±1).
REQ-037 pll_lock never rises -> three 16-cycle reset pulses separated by 4096-cycle waits, then err=1, pll_pwd=1, retry_cnt=3, cfg_ready=1.
REQ-038 In RUN, cfg_valid with cfg_fbdsel=6'd9 -> cfg_ready=1 same cycle, fbdsel=9 next cycle, enclk=0 for 4 cycles, then 16-cycle pll_reset, relock to RUN.
REQ-039 Lock glitch low for 1 cycle at FILTER count 40 -> filter restarts; locked asserts 64 cycles after lock returns.
REQ-040 Lock drop in RUN: with PLL_AUTO_RELOCK_EN -> retry_cnt=1, pll_reset pulse, relock; without -> FAULT, err=1.
REQ-041 rst_n asserted during FILTER -> outputs at reset values immediately, without waiting for a clkin edge.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// PLL lock sequencing and dynamic divider reconfiguration with filtered lock, timeout/retry and clock gating.
// Optional PLL_AUTO_RELOCK_EN: loss of lock in RUN retries a relock instead of going straight to FAULT.
module pll_reconfig_ctrl #(
   parameter int                  NUM_CH       = 1,
   parameter int                  RST_CYCLES   = 16,
   parameter int                  LOCK_FILT    = 64,
   parameter int                  LOCK_TIMEOUT = 4096,
   parameter int                  MAX_RETRY    = 3,
   parameter int                  GATE_CYCLES  = 4,
   parameter logic [5:0]          DEF_IDSEL    = 6'd0,
   parameter logic [5:0]          DEF_FBDSEL   = 6'd0,
   parameter logic [NUM_CH*7-1:0] DEF_ODSEL    = '0
) (
   input  logic                clkin,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [5:0]          cfg_idsel,
   input  logic [5:0]          cfg_fbdsel,
   input  logic [NUM_CH*7-1:0] cfg_odsel,
   input  logic                pll_lock,
   output logic                pll_reset,
   output logic                pll_pwd,
   output logic [5:0]          idsel,
   output logic [5:0]          fbdsel,
   output logic [NUM_CH*7-1:0] odsel,
   output logic [NUM_CH-1:0]   enclk,
   output logic                locked,
   output logic                busy,
   output logic                err,
   output logic [2:0]          retry_cnt
);

   localparam int CMAX0 = (RST_CYCLES > LOCK_FILT) ? RST_CYCLES : LOCK_FILT;
   localparam int CMAX  = (CMAX0 > GATE_CYCLES) ? CMAX0 : GATE_CYCLES;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int TW    = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [2:0] {RST, WAIT_LOCK, FILTER, RUN, GATE, FAULT} state_t;

   state_t        state, state_nx, fail_st;
   logic [1:0]    sync;
   logic          lock_s;
   logic [CW-1:0] cnt, cnt_nx;
   logic [TW-1:0] tmo, tmo_nx;
   logic [2:0]    retry_nx, retry_inc;
   logic          load;

   assign lock_s = sync[1];

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         sync      <= 2'b00;
         state     <= RST;
         cnt       <= '0;
         tmo       <= '0;
         retry_cnt <= 3'd0;
         idsel     <= DEF_IDSEL;
         fbdsel    <= DEF_FBDSEL;
         odsel     <= DEF_ODSEL;
      end else begin
         sync      <= {sync[0], pll_lock};
         state     <= state_nx;
         cnt       <= cnt_nx;
         tmo       <= tmo_nx;
         retry_cnt <= retry_nx;
         if (load) begin
            idsel  <= cfg_idsel;
            fbdsel <= cfg_fbdsel;
            odsel  <= cfg_odsel;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      tmo_nx    = tmo;
      retry_nx  = retry_cnt;
      load      = 1'b0;
      retry_inc = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
      fail_st   = (int'(retry_inc) < MAX_RETRY) ? RST : FAULT;
      pll_reset = 1'b0;
      pll_pwd   = 1'b0;
      enclk     = '0;
      locked    = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
      cfg_ready = 1'b0;
      case (state)
         RST: begin
            pll_reset = 1'b1;
            busy      = 1'b1;
            tmo_nx    = '0;
            if (cnt == CW'(RST_CYCLES - 1)) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         WAIT_LOCK: begin
            busy = 1'b1;
            // timeout keeps accumulating across filter restarts; saturate so a late drop still fails
            if (tmo != TW'(LOCK_TIMEOUT)) tmo_nx = tmo + TW'(1);
            if (lock_s) begin
               state_nx = FILTER;
               cnt_nx   = CW'(1);
            end else if (tmo >= TW'(LOCK_TIMEOUT - 1)) begin
               retry_nx = retry_inc;
               state_nx = fail_st;
               cnt_nx   = '0;
            end
         end
         FILTER: begin
            busy = 1'b1;
            if (tmo != TW'(LOCK_TIMEOUT)) tmo_nx = tmo + TW'(1);
            if (!lock_s) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt >= CW'(LOCK_FILT - 1)) begin
               state_nx = RUN;
               cnt_nx   = '0;
               retry_nx = 3'd0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RUN: begin
            enclk     = '1;
            locked    = 1'b1;
            cfg_ready = 1'b1;
            // a pending handshake wins over a simultaneous lock loss
            if (cfg_valid) begin
               load     = 1'b1;
               state_nx = GATE;
               cnt_nx   = '0;
            end else if (!lock_s) begin
`ifdef PLL_AUTO_RELOCK_EN
               retry_nx = retry_inc;
               state_nx = fail_st;
`else
               state_nx = FAULT;
`endif
               cnt_nx   = '0;
            end
         end
         GATE: begin
            busy = 1'b1;
            if (cnt == CW'(GATE_CYCLES - 1)) begin
               state_nx = RST;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         FAULT: begin
            err       = 1'b1;
            pll_pwd   = 1'b1;
            pll_reset = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               load     = 1'b1;
               retry_nx = 3'd0;
               state_nx = GATE;
               cnt_nx   = '0;
            end
         end
         default: state_nx = RST;
      endcase
   end

endmodule
